// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the multi-precision nibble add sequencer.
package rca_seq_pkg;

  localparam int NIB_W       = 4;
  localparam int NIBBLES_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rca_seq_ctrl_nibble.sv
// 4-bit combinational ripple-carry adder shared by the sequencer.
module rca_nibble
  import rca_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] y,
  output logic             cout
);

  logic [NIB_W:0] c_s;

  // Bitwise full-adder chain
  always_comb begin
    c_s    = {(NIB_W+1){1'b0}};
    y      = {NIB_W{1'b0}};
    c_s[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      y[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
    cout = c_s[NIB_W];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequences a wide add through one shared nibble adder, LS nibble first.
// Optional macro RCA_SEQ_SUB_EN adds op_sub for a-b (cout_out=1 means no borrow).
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] a_in,
  input  logic [NIB_W*NIBBLES-1:0] b_in,
  input  logic                     cin_in,
`ifdef RCA_SEQ_SUB_EN
  input  logic                     op_sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] sum_out,
  output logic                     cout_out,
  output logic                     busy
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_r, state_n;
  logic [W-1:0]     a_r, b_r, sum_r;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r, cout_r;
  logic             in_ready_r, out_valid_r, busy_r;
  logic             accept_s, last_s;
  logic [W-1:0]     b_sel_s;
  logic             cin_sel_s;
  logic [NIB_W-1:0] nib_y_s;
  logic             nib_cout_s;

`ifdef RCA_SEQ_SUB_EN
  // Subtraction is a + ~b + 1; the caller's carry-in is ignored
  assign b_sel_s   = op_sub ? ~b_in : b_in;
  assign cin_sel_s = op_sub ? 1'b1 : cin_in;
`else
  assign b_sel_s   = b_in;
  assign cin_sel_s = cin_in;
`endif

  rca_nibble u_nibble (
    .a    (a_r[NIB_W*idx_r +: NIB_W]),
    .b    (b_r[NIB_W*idx_r +: NIB_W]),
    .cin  (carry_r),
    .y    (nib_y_s),
    .cout (nib_cout_s)
  );

  // Next-state decode
  always_comb begin
    state_n  = state_r;
    accept_s = 1'b0;
    last_s   = (idx_r == IDX_LAST);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_n  = ADD;
        end else begin
          state_n  = IDLE;
        end
      end
      ADD: begin
        if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = ADD;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, handshake flags and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      sum_r       <= {W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
      busy_r      <= (state_n != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a_in;
            b_r     <= b_sel_s;
            carry_r <= cin_sel_s;
            sum_r   <= {W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        ADD: begin
          sum_r[NIB_W*idx_r +: NIB_W] <= nib_y_s;
          carry_r <= nib_cout_s;
          idx_r   <= idx_r + IDX_W'(1);
          if (last_s) begin
            cout_r <= nib_cout_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum_out   = sum_r;
  assign cout_out  = cout_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with an arithmetic reference model.
module tb_rca_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         in_valid, in_ready, cin_in, out_valid, out_ready, cout_out, busy;
  logic [W-1:0] a_in, b_in, sum_out;
`ifdef RCA_SEQ_SUB_EN
  logic         op_sub;
`endif

  logic       s1_in_valid, s1_in_ready, s1_cin, s1_out_valid, s1_out_ready, s1_cout, s1_busy;
  logic [3:0] s1_a, s1_b, s1_sum;

  int vectors     = 0;
  int miscompares = 0;

  rca_seq_ctrl #(.NIBBLES(N)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
`ifdef RCA_SEQ_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .cout_out(cout_out), .busy(busy)
  );

  rca_seq_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
    .a_in(s1_a), .b_in(s1_b), .cin_in(s1_cin),
`ifdef RCA_SEQ_SUB_EN
    .op_sub(1'b0),
`endif
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .sum_out(s1_sum),
    .cout_out(s1_cout), .busy(s1_busy)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
    logic [W-1:0] bi;
    bi = s ? ~b : b;
    return 64'(a) + 64'(bi) + (s ? 64'd1 : 64'(c));
  endfunction

  // Reference: a request occupies N add cycles; after k of them the low k nibbles are final
  bit          busy_m;
  int          k_m;
  logic [63:0] full_m, sum_m;
  logic        cout_m;
  logic        sub_m;

`ifdef RCA_SEQ_SUB_EN
  assign sub_m = op_sub;
`else
  assign sub_m = 1'b0;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_m <= 1'b0; k_m <= 0; full_m <= 64'd0; sum_m <= 64'd0; cout_m <= 1'b0;
    end else if (!busy_m && in_valid) begin
      busy_m <= 1'b1; k_m <= 0; sum_m <= 64'd0;
      full_m <= ref_sum(a_in, b_in, cin_in, sub_m);
    end else if (busy_m && k_m < N) begin
      k_m   <= k_m + 1;
      sum_m <= full_m & ((64'd1 << (4 * (k_m + 1))) - 64'd1);
      if (k_m + 1 == N) cout_m <= full_m[4*N];
    end else if (busy_m && k_m == N && out_ready) begin
      busy_m <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("in_ready",  64'(in_ready),  64'(!busy_m));
      check("out_valid", 64'(out_valid), 64'(busy_m && k_m == N));
      check("busy",      64'(busy),      64'(busy_m));
      check("sum_out",   64'(sum_out),   sum_m);
      if (busy_m && k_m == N) check("cout_out", 64'(cout_out), 64'(cout_m));
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int t;
    t = 0;
    @(negedge clk);
    a_in = a; b_in = b; cin_in = c; in_valid = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    op_sub = s;
`else
    if (s) $display("note: op_sub ignored in this build");
`endif
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("result_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic take(input int n, input logic [W-1:0] es, input logic ec);
    for (int i = 0; i < n; i++) begin
      check("hold_sum",   64'(sum_out),   64'(es));
      check("hold_cout",  64'(cout_out),  64'(ec));
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready),  64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("back_idle_ready", 64'(in_ready),  64'd1);
    check("back_idle_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin_in = 1'b0;
    a_in = '0; b_in = '0;
`ifdef RCA_SEQ_SUB_EN
    op_sub = 1'b0;
`endif
    s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_cin = 1'b0; s1_a = 4'h0; s1_b = 4'h0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_sum",       64'(sum_out),   64'd0);
    check("rst_cout",      64'(cout_out),  64'd0);
    #9 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    // Full carry ripple through every nibble
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_result(lat);
    check("latency", 64'(lat), 64'd4);
    check("t1_sum", 64'(sum_out), 64'h0000);
    check("t1_cout", 64'(cout_out), 64'd1);
    take(0, 16'h0000, 1'b1);

    // Carry-in plus ignored request during ADD
    send(16'h1234, 16'h4321, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555;
    check("t2_ready_in_add", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(lat);
    check("t2_sum", 64'(sum_out), 64'h5556);
    check("t2_cout", 64'(cout_out), 64'd0);
    take(0, 16'h5556, 1'b0);

    // Backpressure
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    wait_result(lat);
    take(5, 16'h1000, 1'b0);

    // Reset in the middle of ADD with idx=2
    send(16'h1111, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t4_partial", 64'(sum_out), 64'h0022);
    #2 reset_n = 1'b0;
    #1;
    check("t4_rst_valid", 64'(out_valid), 64'd0);
    check("t4_rst_sum",   64'(sum_out),   64'd0);
    check("t4_rst_cout",  64'(cout_out),  64'd0);
    check("t4_rst_busy",  64'(busy),      64'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("t4_ready", 64'(in_ready), 64'd1);
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_result(lat);
    check("t4_sum", 64'(sum_out), 64'h0002);
    take(0, 16'h0002, 1'b0);

`ifdef RCA_SEQ_SUB_EN
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_result(lat);
    check("sub1_sum", 64'(sum_out), 64'hFFFE);
    check("sub1_cout", 64'(cout_out), 64'd0);
    take(0, 16'hFFFE, 1'b0);
    send(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_result(lat);
    check("sub2_sum", 64'(sum_out), 64'h0002);
    check("sub2_cout", 64'(cout_out), 64'd1);
    take(0, 16'h0002, 1'b1);
    op_sub = 1'b0;
`endif

    // Single-nibble instance: ADD lasts one cycle
    @(negedge clk);
    check("n1_ready", 64'(s1_in_ready), 64'd1);
    s1_a = 4'hF; s1_b = 4'h1; s1_cin = 1'b1; s1_in_valid = 1'b1;
    @(posedge clk);
    #1 s1_in_valid = 1'b0;
    @(negedge clk);
    check("n1_valid_early", 64'(s1_out_valid), 64'd0);
    check("n1_busy", 64'(s1_busy), 64'd1);
    @(negedge clk);
    check("n1_valid", 64'(s1_out_valid), 64'd1);
    check("n1_sum", 64'(s1_sum), 64'h1);
    check("n1_cout", 64'(s1_cout), 64'd1);
    s1_out_ready = 1'b1;
    @(posedge clk);
    #1 s1_out_ready = 1'b0;
    @(negedge clk);
    check("n1_idle", 64'(s1_in_ready), 64'd1);
    check("n1_valid_drop", 64'(s1_out_valid), 64'd0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rca_seq_ctrl.md
Name: rca_seq_ctrl

Overview:
Multi-precision add sequencer that shares one 4-bit ripple-carry nibble adder across wide operands.
- Accepts two (4*NIBBLES)-bit operands and a carry-in through a valid/ready handshake.
- Drives the nibble adder one nibble per cycle, least significant nibble first, and chains the carry between nibbles.
- Presents the full sum and final carry-out through a second valid/ready handshake.
- Sits between the operand source and the result consumer in the arithmetic datapath.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 1..16.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand source has a request.
in_ready  out  1  controller can accept a request (high only in IDLE).
a_in  in  4*NIBBLES  operand A.
b_in  in  4*NIBBLES  operand B.
cin_in  in  1  initial carry-in.
out_valid  out  1  result available (high only in DONE).
out_ready  in  1  consumer accepts the result.
sum_out  out  4*NIBBLES  registered sum.
cout_out  out  1  registered carry-out of the most significant nibble.
busy  out  1  high in ADD or DONE.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, in_ready=1 once reset deasserts, out_valid=0, busy=0, sum_out=0, cout_out=0.
  - Nibble counter, carry register and operand registers are all cleared.
- FSM states: IDLE, ADD, DONE (enum in package).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a_in, b_in and cin_in into carry_q; clear sum_out; idx=0; go to ADD.
- ADD:
  - The nibble adder sees a_q[4*idx+:4], b_q[4*idx+:4] and carry_q, combinationally.
  - On each edge: sum_out[4*idx+:4] <= y; carry_q <= nibble carry-out; idx <= idx+1.
  - When idx==NIBBLES-1 at the edge: cout_out <= nibble carry-out; go to DONE.
- DONE:
  - out_valid=1; sum_out and cout_out stable.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
  - sum_out and cout_out hold their values until the next accept.
- Latency: out_valid rises exactly NIBBLES cycles after the accept edge. With NIBBLES=4, accept at edge 0 gives out_valid high after edge 4.
- Throughput: one request per NIBBLES+2 cycles at best, since in_ready is low through ADD and DONE.
- in_valid during ADD or DONE is ignored. The source must hold the request stable until in_ready.
- out_ready outside DONE is ignored.
- Arithmetic:
  - Addition is modulo 2^(4*NIBBLES).
  - Carry propagates only through carry_q. There is no lookahead.
  - cout_out equals bit 4*NIBBLES of a+b+cin.
- Counter width is max(1, $clog2(NIBBLES)). With NIBBLES=1, ADD lasts exactly one cycle.
- Reset asserted mid-ADD or in DONE: immediate return to IDLE with all outputs cleared. The partial result is discarded.

Optional Feature:
RCA_SEQ_SUB_EN
- Defined:
  - Adds input port op_sub (1 bit), sampled with the operands at accept.
  - When op_sub=1, the controller stores ~b_in and forces carry_q=1 (cin_in ignored), so the block computes a-b.
  - cout_out=1 means no borrow.
- Undefined: no op_sub port; the block only computes a+b+cin.

Decomposition:
- Package rca_seq_pkg:
  - state enum (IDLE, ADD, DONE)
  - NIB_W=4 constant
  - NIBBLES_MAX=16 constant
- Sub-module rca_nibble: 4-bit combinational ripple adder with inputs a[3:0], b[3:0], cin and outputs y[3:0], cout (1 bit). It is instantiated once.
- All sequencing stays in rca_seq_ctrl.

Test Plan:
- NIBBLES=4, a=16'hFFFF, b=16'h0001, cin=0 -> out_valid exactly 4 cycles after accept, sum_out=16'h0000, cout_out=1.
- a=16'h1234, b=16'h4321, cin=1 -> sum_out=16'h5556, cout_out=0. in_valid pulsed during ADD is ignored and in_ready stays 0.
- Backpressure: result 16'h0F0F+16'h00F1 held with out_ready=0 for 5 cycles -> out_valid, sum_out=16'h1000 and cout_out=0 stay stable, in_ready stays 0. out_ready=1 -> IDLE next cycle with in_ready=1.
- reset_n pulsed low while idx=2 in ADD -> out_valid=0, sum_out=0, cout_out=0 immediately. After release in_ready=1, and a new request 16'h0001+16'h0001 -> 16'h0002.
- NIBBLES=1: a=4'hF, b=4'h1, cin=1 -> out_valid 1 cycle after accept, sum_out=4'h1, cout_out=1.
- With RCA_SEQ_SUB_EN: op_sub=1, a=16'h0005, b=16'h0007 -> sum_out=16'hFFFE, cout_out=0. op_sub=1, a=16'h0007, b=16'h0005 -> 16'h0002, cout_out=1.
